// File: rtl/code_ser_pkg.sv
// Shared definitions for the code serializer: code width, FSM encoding and
// index-width helpers.
package code_ser_pkg;

  localparam int CODE_W = 3;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // An idx counter still needs one bit when a word holds a single code.
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/code_ser_ctrl.sv
// Serializer control: IDLE/SHIFT state, code index counter, ready and
// last-code generation. state_o exposes the FSM state for observation.
module code_ser_ctrl
  import code_ser_pkg::*;
#(
  parameter int NCODES = 10,
  parameter int IDX_W  = idx_width(NCODES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic             hold_i,
  output logic             in_ready_o,
  output logic             load_o,
  output logic             last_code_o,
  output logic             state_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             run_q;
  logic             last;

  assign last = (state_q == ST_SHIFT) && (idx_q == IDX_W'(NCODES - 1));

  // run_q keeps in_ready low until the first clock after reset is released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (load_o) begin
          state_d = ST_SHIFT;
          idx_d   = '0;
        end
      end
      default: begin
        if (!hold_i) begin
          if (!last) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (load_o) begin
            idx_d = '0;
          end else begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end
        end
      end
    endcase
  end

  // Handshake: a word transfers on a posedge where in_valid_i && in_ready_o;
  // in_ready_o depends only on registered state and hold, never on in_valid_i.
  always_comb begin
    in_ready_o  = run_q && ((state_q == ST_IDLE) || (last && !hold_i));
    load_o      = in_valid_i && in_ready_o;
    last_code_o = last;
    state_o     = state_q;
    idx_o       = idx_q;
  end

endmodule

// File: rtl/code_serializer.sv
// Unpacks a WIDTH-bit word into NCODES 3-bit codes, LSB group first, one per
// cycle. Define CODE_SER_WORDCNT_EN to add the 16-bit words_done counter.
module code_serializer
  import code_ser_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NCODES = WIDTH / CODE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             hold,
  output logic [WIDTH-1:0] data_out,
  output logic             code_valid,
`ifdef CODE_SER_WORDCNT_EN
  output logic [15:0]      words_done,
`endif
  output logic             last_code
);

  localparam int IDX_W = idx_width(NCODES);

  logic              load;
  logic              state;
  logic [IDX_W-1:0]  idx;
  logic [WIDTH-1:0]  word_q;
  logic [CODE_W-1:0] codes [NCODES];
  logic [CODE_W-1:0] code;

  code_ser_ctrl #(
    .NCODES(NCODES),
    .IDX_W (IDX_W)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .hold_i     (hold),
    .in_ready_o (in_ready),
    .load_o     (load),
    .last_code_o(last_code),
    .state_o    (state),
    .idx_o      (idx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      word_q <= '0;
    end else if (load) begin
      word_q <= data_in;
    end
  end

  for (genvar g = 0; g < NCODES; g++) begin : g_codes
    assign codes[g] = word_q[g*CODE_W +: CODE_W];
  end

  // Word bits above the last whole code never reach the output.
  if (WIDTH > NCODES * CODE_W) begin : g_spare
    logic unused_hi;
    assign unused_hi = ^word_q[WIDTH-1:NCODES*CODE_W];
  end

  assign code       = codes[idx];
  assign code_valid = (state == ST_SHIFT);
  assign data_out   = code_valid ? {{(WIDTH-CODE_W){1'b0}}, code} : '0;

`ifdef CODE_SER_WORDCNT_EN
  logic [15:0] words_done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      words_done_q <= '0;
    end else if (last_code && !hold) begin
      words_done_q <= words_done_q + 16'd1;
    end
  end

  assign words_done = words_done_q;
`endif

endmodule

// File: tb/tb_code_serializer.sv
// Self-checking bench for code_serializer: scoreboard of expected codes plus
// per-scenario tasks for reset, single word, back-to-back, hold and random.
module tb_code_serializer;

  localparam int WIDTH  = 32;
  localparam int NCODES = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             in_valid = 1'b0;
  logic             hold = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] data_out;
  logic             code_valid;
  logic             last_code;
`ifdef CODE_SER_WORDCNT_EN
  logic [15:0]      words_done;
`endif

  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;
  int tests_run = 0;
  int fails = 0;

  code_serializer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .hold      (hold),
    .data_out  (data_out),
    .code_valid(code_valid),
`ifdef CODE_SER_WORDCNT_EN
    .words_done(words_done),
`endif
    .last_code (last_code)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare the live code to the queue head, pop on advance,
  // push ten expected codes whenever a word is accepted.
  always @(negedge clk) begin
    if (code_valid === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL code_unexpected: data_out=%h last=%b with no expected code", data_out, last_code);
      end else begin
        mon_exp = exp_q[0];
        if (data_out !== {28'b0, mon_exp[2:0]} || last_code !== mon_exp[3]) begin
          fails++;
          $display("FAIL code_stream: data_out=%h last=%b expected code=%0d last=%b",
                   data_out, last_code, mon_exp[2:0], mon_exp[3]);
        end
        if (rst === 1'b1 && hold === 1'b0) void'(exp_q.pop_front());
      end
    end else begin
      tests_run++;
      if (code_valid !== 1'b0 || data_out !== '0 || last_code !== 1'b0) begin
        fails++;
        $display("FAIL idle_outputs: code_valid=%b data_out=%h last=%b expected 0,0,0",
                 code_valid, data_out, last_code);
      end
    end
    if (rst !== 1'b1) begin
      exp_q.delete();
    end else if (in_valid === 1'b1 && in_ready === 1'b1) begin
      for (int i = 0; i < NCODES; i++)
        exp_q.push_back({(i == NCODES - 1), data_in[i*3 +: 3]});
    end
  end

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((code_valid !== 1'b0 || exp_q.size() != 0) && n < 40) begin
      step();
      n++;
    end
    tests_run++;
    if (code_valid !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_%s: code_valid=%b pending=%0d after %0d cycles, expected idle and empty",
               name, code_valid, exp_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b1;
    hold = 1'b0;
    data_in = $urandom;
    for (int c = 0; c < 3; c++) begin
      step();
      tests_run++;
      if (in_ready !== 1'b0 || data_out !== '0 || code_valid !== 1'b0 || last_code !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs: cycle=%0d in_ready=%b data_out=%h code_valid=%b last=%b expected all 0",
                 c, in_ready, data_out, code_valid, last_code);
      end
    end
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_single();
    int single_codes [NCODES] = '{3, 2, 1, 0, 0, 0, 0, 0, 0, 0};
    data_in = 32'h0000_0053;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    data_in = $urandom;
    for (int i = 0; i < NCODES; i++) begin
      tests_run++;
      if (code_valid !== 1'b1 || last_code !== (i == NCODES - 1) || data_out !== 32'(single_codes[i])) begin
        fails++;
        $display("FAIL single_word: idx=%0d data_out=%h valid=%b last=%b expected code=%0d valid=1 last=%b",
                 i, data_out, code_valid, last_code, single_codes[i], (i == NCODES - 1));
      end
      step();
    end
    tests_run++;
    if (code_valid !== 1'b0 || data_out !== '0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL single_idle: valid=%b data_out=%h in_ready=%b expected 0,0,1", code_valid, data_out, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    data_in = 32'h3FFF_FFFF;
    step();
    for (int i = 0; i < NCODES; i++) begin
      data_in = (i == NCODES - 1) ? 32'h0 : $urandom;
      tests_run++;
      if (code_valid !== 1'b1 || data_out !== 32'd7 || in_ready !== (i == NCODES - 1) ||
          last_code !== (i == NCODES - 1)) begin
        fails++;
        $display("FAIL b2b_word1: idx=%0d data_out=%h valid=%b ready=%b last=%b expected 7,1,%b,%b",
                 i, data_out, code_valid, in_ready, last_code, (i == NCODES - 1), (i == NCODES - 1));
      end
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < NCODES; i++) begin
      tests_run++;
      if (code_valid !== 1'b1 || data_out !== 32'd0 || in_ready !== (i == NCODES - 1) ||
          last_code !== (i == NCODES - 1)) begin
        fails++;
        $display("FAIL b2b_word2: idx=%0d data_out=%h valid=%b ready=%b last=%b expected 0,1,%b,%b",
                 i, data_out, code_valid, in_ready, last_code, (i == NCODES - 1), (i == NCODES - 1));
      end
      step();
    end
    wait_drain("b2b");
  endtask

  task automatic test_hold();
    data_in = 32'h2AAA_AAAA;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (in_ready !== 1'b0 || code_valid !== 1'b1 || data_out !== 32'd2 || last_code !== 1'b0) begin
        fails++;
        $display("FAIL hold_frozen: k=%0d data_out=%h ready=%b valid=%b last=%b expected 2,0,1,0",
                 k, data_out, in_ready, code_valid, last_code);
      end
      step();
    end
    tests_run++;
    if (data_out !== 32'd2 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL hold_end: data_out=%h ready=%b expected 2,0", data_out, in_ready);
    end
    hold = 1'b0;
    step();
    tests_run++;
    if (data_out !== 32'd5 || code_valid !== 1'b1) begin
      fails++;
      $display("FAIL hold_resume: data_out=%h valid=%b expected code 5 (index 5)", data_out, code_valid);
    end
    wait_drain("hold");
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] w1;
    logic [WIDTH-1:0] w2;
    w1 = $urandom;
    w2 = $urandom;
    data_in = w1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    rst = 1'b0;
    step();
    tests_run++;
    if (code_valid !== 1'b0 || data_out !== '0 || in_ready !== 1'b0 || last_code !== 1'b0) begin
      fails++;
      $display("FAIL midreset_idle: valid=%b data_out=%h ready=%b last=%b expected all 0",
               code_valid, data_out, in_ready, last_code);
    end
    rst = 1'b1;
    step();
    tests_run++;
    if (in_ready !== 1'b1 || code_valid !== 1'b0) begin
      fails++;
      $display("FAIL midreset_release: ready=%b valid=%b expected 1,0", in_ready, code_valid);
    end
    data_in = w2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    tests_run++;
    if (code_valid !== 1'b1 || data_out !== {29'b0, w2[2:0]}) begin
      fails++;
      $display("FAIL midreset_restart: valid=%b data_out=%h expected 1,%h", code_valid, data_out, w2[2:0]);
    end
    wait_drain("midreset");
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      data_in = $urandom;
      hold = ($urandom_range(0, 4) == 0);
      #1;
      tests_run++;
      if ((code_valid === 1'b0 && in_ready !== 1'b1) ||
          (code_valid === 1'b1 && in_ready !== (last_code && !hold))) begin
        fails++;
        $display("FAIL random_ready: cycle=%0d valid=%b last=%b hold=%b ready=%b",
                 c, code_valid, last_code, hold, in_ready);
      end
      step();
    end
    in_valid = 1'b0;
    hold = 1'b0;
    wait_drain("random");
  endtask

`ifdef CODE_SER_WORDCNT_EN
  task automatic test_wordcnt();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    tests_run++;
    if (words_done !== 16'd0) begin
      fails++;
      $display("FAIL wordcnt_reset: words_done=%0d expected 0", words_done);
    end
    for (int k = 1; k <= 3; k++) begin
      data_in = $urandom;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_drain("wordcnt");
      tests_run++;
      if (words_done !== 16'(k)) begin
        fails++;
        $display("FAIL wordcnt_count: words_done=%0d expected %0d", words_done, k);
      end
    end
    dut.words_done_q = 16'hFFFF;
    data_in = $urandom;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_drain("wordcnt_wrap");
    tests_run++;
    if (words_done !== 16'd0) begin
      fails++;
      $display("FAIL wordcnt_wrap: words_done=%0d expected 0", words_done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_random();
`ifdef CODE_SER_WORDCNT_EN
    test_wordcnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
